shift_right_seq: RTL and testbench

- Multi-cycle right shifter for the MIPS datapath; the counterpart to the fixed left-by-2 shifter.
- Executes SRL/SRA/SRLV/SRAV-style operations by shifting up to STEP bit positions per clock, which keeps the combinational path short.
- Sits beside the ALU. Operands are accepted through a valid/ready input handshake, and the result is returned through a valid/ready output handshake.

---
 rtl/shift_right_seq_if.sv | 26 ++
 rtl/shift_right_seq.sv | 102 ++++++++++
 tb/tb_shift_right_seq.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/shift_right_seq_if.sv
// Operand/result handshake bundle for the multi-cycle right shifter.
// The master drives operands and result acceptance; the slave is the shifter.
interface shift_right_seq_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic               in_arith;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               busy;

    modport master (
        output in_valid, in_data, in_shamt, in_arith, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_arith, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/shift_right_seq.sv
// Multi-cycle logical/arithmetic right shifter: shifts at most STEP bits per clock,
// taking operands and returning results over valid/ready handshakes.
module shift_right_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_right_seq_if.slave  bus
);
    localparam int K_W = SHAMT_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic               arith_q, arith_d;
    logic               sign_q, sign_d;

    logic               accept;
    logic [K_W-1:0]     k;
    logic [WIDTH-1:0]   fill;
    logic [WIDTH-1:0]   shifted;

    assign accept = bus.in_valid && (state_q == IDLE);

    // Per-cycle shift step: k = min(remaining, STEP); vacated MSBs take the fill pattern.
    always_comb begin
        if ({1'b0, rem_q} > K_W'(STEP)) begin
            k = K_W'(STEP);
        end else begin
            k = {1'b0, rem_q};
        end
        fill    = (arith_q && sign_q) ? '1 : '0;
        shifted = (data_q >> k) | (fill & ~({WIDTH{1'b1}} >> k));
    end

    // NOTE: state/data registers use non-blocking assignments so every flop samples
    // pre-edge values; reset clears all of them asynchronously, aborting any shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            rem_q   <= '0;
            arith_q <= 1'b0;
            sign_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            rem_q   <= rem_d;
            arith_q <= arith_d;
            sign_q  <= sign_d;
        end
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = (bus.in_shamt == '0) ? DONE : SHIFT;
            SHIFT:   if (rem_q == SHAMT_W'(k)) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        rem_d   = rem_q;
        arith_d = arith_q;
        sign_d  = sign_q;
        if (accept) begin
            data_d  = bus.in_data;
            rem_d   = bus.in_shamt;
            arith_d = bus.in_arith;
            sign_d  = bus.in_data[WIDTH-1];
        end else if (state_q == SHIFT) begin
            data_d = shifted;
            rem_d  = rem_q - k[SHAMT_W-1:0];
        end
    end

    // Outputs decode straight from registers, so reset shows on them without a clock edge.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.busy      = (state_q != IDLE);
        bus.out_data  = data_q;
    end
endmodule

// File: tb/tb_shift_right_seq.sv
// Directed bench for shift_right_seq: hand-computed results, latencies, backpressure
// and asynchronous reset behaviour.
module tb_shift_right_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    shift_right_seq_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    shift_right_seq #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one operand, wait for the result, compare data and latency, then consume it.
    // Latency = clock edges from the accept edge to the edge that first sees out_valid high.
    task automatic run_op(input string tag, input logic [31:0] data, input logic [4:0] shamt,
                          input logic arith, input logic [31:0] exp_data, input int exp_lat);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_shamt = shamt;
        bus.in_arith = arith;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'hA5A5_A5A5;
        bus.in_shamt = 5'd7;
        bus.in_arith = ~arith;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, bus.out_data, exp_data);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_idle_after"}, {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
        check({tag, "_data_held"}, bus.out_data, exp_data);
    endtask

    initial begin
        int pulses;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_arith  = 1'b0;
        bus.out_ready = 1'b0;

        #12;
        check("reset_flags", {29'd0, bus.in_ready, bus.out_valid, bus.busy}, 32'b100);
        check("reset_data", bus.out_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("zero_shift", 32'h1234_5678, 5'd0, 1'b0, 32'h1234_5678, 1);

        // Asynchronous reset pulse mid-clock: outputs must clear before any edge.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_flags", {29'd0, bus.in_ready, bus.out_valid, bus.busy}, 32'b100);
        check("async_rst_data", bus.out_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("lsr4", 32'hF000_0000, 5'd4, 1'b0, 32'h0F00_0000, 2);
        run_op("asr31", 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 9);
        run_op("lsr31", 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 9);
        run_op("asr5", 32'h8765_4321, 5'd5, 1'b1, 32'hFC3B_2A19, 3);
        run_op("lsr5", 32'h8765_4321, 5'd5, 1'b0, 32'h043B_2A19, 3);

        // Backpressure with a competing operand held on the input while busy.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h8000_0000;
        bus.in_shamt = 5'd8;
        bus.in_arith = 1'b1;
        @(posedge clk);
        #1;
        bus.in_data  = 32'hDEAD_BEEF;
        bus.in_shamt = 5'd0;
        bus.in_arith = 1'b0;
        @(negedge clk);
        check("bp_busy_ready", {30'd0, bus.busy, bus.in_ready}, 32'b10);
        repeat (3) @(negedge clk);
        check("bp_valid", 32'(bus.out_valid), 32'd1);
        check("bp_data_first", bus.out_data, 32'hFF80_0000);
        repeat (10) @(negedge clk);
        check("bp_data_stalled", bus.out_data, 32'hFF80_0000);
        check("bp_stall_flags", {29'd0, bus.in_ready, bus.out_valid, bus.busy}, 32'b011);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("bp_idle_after", {29'd0, bus.in_ready, bus.out_valid, bus.busy}, 32'b100);
        repeat (2) @(negedge clk);
        check("bp_no_second_op", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
        run_op("after_bp", 32'h0000_00F0, 5'd4, 1'b0, 32'h0000_000F, 2);

        // Reset in the middle of a shift discards the operation.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h8000_0000;
        bus.in_shamt = 5'd20;
        bus.in_arith = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        check("mid_shift_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_flags", {29'd0, bus.in_ready, bus.out_valid, bus.busy}, 32'b100);
        check("mid_rst_data", bus.out_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) pulses++;
        end
        check("mid_rst_no_valid", 32'(pulses), 32'd0);
        run_op("after_rst", 32'h0000_0100, 5'd8, 1'b0, 32'h0000_0001, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
